// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the instruction fetch front end
package fetch_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and count; a pop frees the slot a same-cycle push uses at full.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC, imem issue/credit, redirect and end-of-program FSM; optional FETCH_TRACE_EN trace
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              IMEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    localparam int             ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr,
    output logic              done
);

    localparam int              CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] END_PC = XLEN'(4 * IMEM_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;

    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W:0]   pending;
    logic             issue, push, pop;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head, push_entry;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Credit check: only issue when the word still in flight plus the new one will fit after this pop.
    always_comb begin
        out_valid       = (fifo_count != '0);
        pop             = out_valid && out_ready;
        redirect_target = redirect_pc & ~XLEN'(3);
        pending         = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        issue           = (state_q == FETCH) && !redirect_valid && !rst && (pc_q < END_PC)
                          && (pending < (CNT_W + 1)'(FIFO_DEPTH));
        push            = inflight_q && !redirect_valid;
        push_entry      = '{pc: inflight_pc_q, instr: imem_rdata};
        pc_d            = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
        inflight_d    = issue;
        inflight_pc_d = pc_q;
    end

    // FSM next state: stop issuing at the image end, finish once everything fetched is consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (pc_d >= END_PC) state_d = DRAIN;
            DRAIN:   if (!inflight_q && (fifo_count == CNT_W'(pop))) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = FETCH;
        endcase
        if (redirect_valid) begin
            state_d = (redirect_target >= END_PC) ? DRAIN : FETCH;
        end
    end

    // State, PC and in-flight tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q[ADDR_W+1:2];
    assign out_pc    = out_valid ? fifo_head.pc : '0;
    assign out_instr = out_valid ? fifo_head.instr : '0;
    assign done      = (state_q == DONE);

`ifdef FETCH_TRACE_EN
    logic [31:0] idx_q, idx_d;

    // Count of delivered instructions for the trace log.
    always_comb begin
        idx_d = idx_q;
        if (pop) idx_d = idx_q + 32'd1;
    end

    // Log each delivered instruction and the end-of-program marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (pop) $display("Instruction %0d: %b", idx_q, out_instr);
            if ((state_q != DONE) && (state_d == DONE)) $display("End of Instructions.");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int IMEM_DEPTH = 5;
    localparam int AW         = $clog2(IMEM_DEPTH);
    localparam int END_PC     = 4 * IMEM_DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic          req_a, valid_a, ready_a, done_a;
    logic [AW-1:0] addr_a;
    logic [31:0]   rdata_a, pc_a, instr_a;
    logic          req_b, valid_b, ready_b, done_b;
    logic [AW-1:0] addr_b;
    logic [31:0]   rdata_b, pc_b, instr_b;

    logic [31:0] mem [IMEM_DEPTH];

    int checks   = 0;
    int failures = 0;
    int n;
    int tc [16];
    logic [31:0] tpc [16];
    logic [31:0] tin [16];

    always #5 clk = ~clk;

    fetch_sequencer #(.IMEM_DEPTH(IMEM_DEPTH), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid_a), .out_ready(ready_a), .out_pc(pc_a), .out_instr(instr_a), .done(done_a)
    );

    fetch_sequencer #(.IMEM_DEPTH(IMEM_DEPTH), .FIFO_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid_b), .out_ready(ready_b), .out_pc(pc_b), .out_instr(instr_b), .done(done_b)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (int'(a) < IMEM_DEPTH) ? mem[a] : 32'hBAD0_BAD0;
    endfunction

    always_ff @(posedge clk) begin
        rdata_a <= req_a ? mem_word(addr_a) : 32'hDEAD_BEEF;
        rdata_b <= req_b ? mem_word(addr_b) : 32'hDEAD_BEEF;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ready_a = 1'b0; ready_b = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        n = 0;
    endtask

    task automatic sample_a(input int c);
        if (valid_a && ready_a && n < 16) begin
            tc[n] = c; tpc[n] = pc_a; tin[n] = instr_a; n++;
        end
    endtask

    task automatic check_stream(input string name, input int first_pc);
        int exp_n;
        exp_n = (END_PC - first_pc) / 4;
        checks++;
        if (n !== exp_n) begin
            failures++; $display("FAIL %s count: got %0d want %0d", name, n, exp_n);
        end
        for (int i = 0; i < n && i < exp_n; i++) begin
            checks++;
            if (tpc[i] !== 32'(first_pc + 4 * i) || tin[i] !== 32'((first_pc + 4 * i) / 4 + 1)) begin
                failures++;
                $display("FAIL %s item %0d: got pc=%0h instr=%0h want pc=%0h instr=%0h", name, i,
                         tpc[i], tin[i], first_pc + 4 * i, (first_pc + 4 * i) / 4 + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        checks++;
        if ({req_a, valid_a, done_a, req_b, valid_b, done_b} !== 6'b0 || pc_a !== 0 || instr_a !== 0) begin
            failures++;
            $display("FAIL reset: got req=%b valid=%b done=%b pc=%0h instr=%0h want all zero",
                     req_a, valid_a, done_a, pc_a, instr_a);
        end
    endtask

    task automatic test_straight();
        int done_cyc;
        bit late_req;
        do_reset(); ready_a = 1'b1; done_cyc = -1; late_req = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            sample_a(c);
            if (done_a && done_cyc < 0) done_cyc = c;
            if (c >= 5 && req_a) late_req = 1;
            cyc();
        end
        check_stream("straight", 0);
        for (int i = 0; i < n && i < 5; i++) begin
            checks++;
            if (tc[i] !== i + 2) begin
                failures++; $display("FAIL straight cycle %0d: got %0d want %0d", i, tc[i], i + 2);
            end
        end
        checks++;
        if (done_cyc !== 7) begin
            failures++; $display("FAIL straight done cycle: got %0d want 7", done_cyc);
        end
        checks++;
        if (late_req !== 1'b0) begin
            failures++; $display("FAIL straight req after end: got 1 want 0");
        end
    endtask

    task automatic test_backpressure();
        int reqs, reqs_held;
        bit hold_bad;
        do_reset(); reqs = 0; hold_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_a) reqs++;
            if (c >= 2 && (!valid_a || pc_a !== 0 || instr_a !== 1)) hold_bad = 1;
            cyc();
        end
        reqs_held = reqs;
        ready_a = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            sample_a(c);
            if (req_a) reqs++;
            cyc();
        end
        checks++;
        if (reqs_held !== 4) begin
            failures++; $display("FAIL backpressure reqs: got %0d want 4", reqs_held);
        end
        checks++;
        if (hold_bad) begin
            failures++; $display("FAIL backpressure head hold: got unstable head want pc 0 held");
        end
        checks++;
        if (reqs !== 5) begin
            failures++; $display("FAIL backpressure total reqs: got %0d want 5", reqs);
        end
        check_stream("backpressure", 0);
    endtask

    task automatic test_redirect();
        int k;
        do_reset();
        for (int c = 0; c < 3; c++) cyc();
        ready_a = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd8;
        @(negedge clk);
        checks++;
        if (req_a !== 1'b0) begin
            failures++; $display("FAIL redirect req in R: got 1 want 0");
        end
        sample_a(3);
        cyc();
        redirect_valid = 1'b0;
        for (int c = 4; c < 20; c++) begin
            @(negedge clk); sample_a(c); cyc();
        end
        checks++;
        if (n !== 4 || tpc[0] !== 0 || tin[0] !== 1) begin
            failures++; $display("FAIL redirect head: got n=%0d pc=%0h want n=4 pc=0", n, tpc[0]);
        end
        k = 0;
        for (int i = 1; i < n; i++) begin
            tpc[k] = tpc[i]; tin[k] = tin[i]; k++;
        end
        n = k;
        check_stream("redirect", 8);
    endtask

    task automatic test_out_of_range();
        bit any_req;
        int done_seen;
        do_reset(); ready_a = 1'b1; any_req = 0; done_seen = -1;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            sample_a(c);
            if (req_a) any_req = 1;
            if (done_a && done_seen < 0) done_seen = c;
            cyc();
            redirect_valid = 1'b0;
        end
        checks++;
        if (any_req) begin
            failures++; $display("FAIL oor req: got 1 want 0");
        end
        checks++;
        if (done_seen < 0 || done_seen > 2) begin
            failures++; $display("FAIL oor done latency: got %0d want <=2", done_seen);
        end
        checks++;
        if (n !== 0) begin
            failures++; $display("FAIL oor transfers: got %0d want 0", n);
        end
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            failures++; $display("FAIL oor done clear: got 1 want 0");
        end
        for (int c = 0; c < 15; c++) begin
            sample_a(c); cyc(); @(negedge clk);
        end
        check_stream("oor refetch", 0);
    endtask

    task automatic test_reset_midstream();
        do_reset(); ready_a = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || done_a !== 1'b0 || req_a !== 1'b1 || addr_a !== '0) begin
            failures++;
            $display("FAIL midreset: got valid=%b done=%b req=%b addr=%0d want 0 0 1 0",
                     valid_a, done_a, req_a, addr_a);
        end
        n = 0;
        for (int c = 5; c < 17; c++) begin
            sample_a(c); cyc(); @(negedge clk);
        end
        check_stream("midreset", 0);
    endtask

    task automatic test_random();
        int  exp_pc, xfers;
        bit  want_redirect;
        logic [31:0] target;
        do_reset(); exp_pc = 0; xfers = 0; want_redirect = 0;
        for (int c = 0; c < 1000; c++) begin
            ready_b = 1'($urandom_range(0, 1));
            redirect_valid = 1'b0;
            if (want_redirect || $urandom_range(0, 49) == 0) begin
                redirect_valid = 1'b1;
                target = ($urandom_range(0, 9) == 0) ? 32'h0000_0100
                                                     : 32'($urandom_range(0, 6) * 4 + $urandom_range(0, 3));
                redirect_pc = target;
                want_redirect = 0;
            end
            @(negedge clk);
            if (valid_b && ready_b) begin
                xfers++; checks++;
                if (exp_pc >= END_PC || pc_b !== 32'(exp_pc) || instr_b !== 32'(exp_pc / 4 + 1)) begin
                    failures++;
                    $display("FAIL random xfer cycle %0d: got pc=%0h instr=%0h want pc=%0h instr=%0h",
                             c, pc_b, instr_b, exp_pc, exp_pc / 4 + 1);
                end
                exp_pc += 4;
            end
            if (done_b) begin
                checks++;
                if (exp_pc < END_PC || valid_b) begin
                    failures++;
                    $display("FAIL random done cycle %0d: got done with exp_pc=%0h valid=%b want all consumed",
                             c, exp_pc, valid_b);
                end
                if (!redirect_valid) want_redirect = 1;
            end
            if (redirect_valid) exp_pc = int'(redirect_pc & ~32'd3);
            cyc();
        end
        redirect_valid = 1'b0;
        checks++;
        if (xfers < 100) begin
            failures++; $display("FAIL random progress: got %0d transfers want >=100", xfers);
        end
    endtask

    task automatic test_sustained();
        int first;
        redirect_valid = 1'b1; redirect_pc = 32'd0; ready_b = 1'b1; n = 0;
        cyc();
        redirect_valid = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (valid_b && n < 16) begin
                tc[n] = c; tpc[n] = pc_b; tin[n] = instr_b; n++;
            end
            cyc();
        end
        check_stream("sustained", 0);
        first = tc[0];
        checks++;
        if (first !== 3) begin
            failures++; $display("FAIL sustained first cycle: got %0d want 3", first);
        end
        for (int i = 1; i < n; i++) begin
            checks++;
            if (tc[i] !== first + i) begin
                failures++; $display("FAIL sustained gap at %0d: got cycle %0d want %0d", i, tc[i], first + i);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = 32'(i + 1);
        ready_a = 1'b0; ready_b = 1'b0;
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_out_of_range();
        test_reset_midstream();
        test_random();
        test_sustained();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
